// File: rtl/fizzbuzz_sequencer_if.sv
// Start/limit request and result stream between a host and the fizzbuzz sequencer.
// master = host/consumer side, slave = sequencer side.
interface fizzbuzz_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] limit;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic [1:0]       out_kind;

  modport master (
    output start, limit, out_ready,
    input  busy, done, out_valid, out_value, out_kind
  );

  modport slave (
    input  start, limit, out_ready,
    output busy, done, out_valid, out_value, out_kind
  );
endinterface

// File: rtl/fizzbuzz_sequencer.sv
// Counts 1..limit and classifies each value as number/fizz/buzz/fizzbuzz,
// streaming one result per valid/ready handshake. Divisibility is tracked
// with wrapping mod-3 and mod-5 counters, so no dividers are needed.
module fizzbuzz_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fizzbuzz_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] limit_q,     limit_d;
  logic [WIDTH-1:0] out_value_q, out_value_d;
  logic [1:0]       out_kind_q,  out_kind_d;
  logic [1:0]       mod3_q,      mod3_d;
  logic [2:0]       mod5_q,      mod5_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  // Wrapped successors of the divisibility counters for the next value.
  logic [1:0] mod3_inc;
  logic [2:0] mod5_inc;

  assign mod3_inc = (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
  assign mod5_inc = (mod5_q == 3'd4) ? 3'd0 : mod5_q + 3'd1;

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    limit_d     = limit_q;
    out_value_d = out_value_q;
    out_kind_d  = out_kind_q;
    mod3_d      = mod3_q;
    mod5_d      = mod5_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.limit != '0) begin
            limit_d     = bus.limit;
            out_value_d = WIDTH'(1);
            mod3_d      = 2'd1;
            mod5_d      = 3'd1;
            out_kind_d  = 2'd0;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_RUN;
          end else begin
            // Empty run: no results, just the completion pulse.
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (out_valid_q && bus.out_ready) begin
          if (out_value_q == limit_q) begin
            // Last value accepted; never increments past limit, so no wrap.
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            out_value_d = out_value_q + WIDTH'(1);
            mod3_d      = mod3_inc;
            mod5_d      = mod5_inc;
            out_kind_d  = {(mod5_inc == 3'd0), (mod3_inc == 2'd0)};
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any run in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      limit_q     <= '0;
      out_value_q <= '0;
      out_kind_q  <= 2'd0;
      mod3_q      <= 2'd0;
      mod5_q      <= 3'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      limit_q     <= limit_d;
      out_value_q <= out_value_d;
      out_kind_q  <= out_kind_d;
      mod3_q      <= mod3_d;
      mod5_q      <= mod5_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_kind  = out_kind_q;

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// Directed bench for fizzbuzz_sequencer: a WIDTH=16 instance for the main
// scenarios and a WIDTH=4 instance for the full-range limit case.
module tb_fizzbuzz_sequencer;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  fizzbuzz_sequencer_if #(.WIDTH(16)) bus16 ();
  fizzbuzz_sequencer_if #(.WIDTH(4))  bus4 ();

  fizzbuzz_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  fizzbuzz_sequencer #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Kinds for values 1..15 (index = value-1), computed by hand.
  logic [1:0] kinds15 [15] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0,
                               2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3};
  bit ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int dones;
    int n_acc;
    logic [15:0] last_val;
    logic        prev_valid;
    logic        prev_ready;
    logic [15:0] prev_value;
    bit          r;

    rst = 1'b1;
    bus16.start = 1'b0; bus16.limit = '0; bus16.out_ready = 1'b0;
    bus4.start  = 1'b0; bus4.limit  = '0; bus4.out_ready  = 1'b0;
    #12;
    check("rst_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_busy",  32'(bus16.busy),      32'd0);
    check("rst_done",  32'(bus16.done),      32'd0);
    check("rst_value", 32'(bus16.out_value), 32'd0);
    check("rst_kind",  32'(bus16.out_kind),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Limit 15, ready held high: one result per cycle.
    bus16.limit = 16'd15; bus16.start = 1'b1; bus16.out_ready = 1'b1;
    step();
    bus16.start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check("l15_valid", 32'(bus16.out_valid), 32'd1);
      check("l15_busy",  32'(bus16.busy),      32'd1);
      check("l15_done",  32'(bus16.done),      32'd0);
      check("l15_value", 32'(bus16.out_value), 32'(i));
      check("l15_kind",  32'(bus16.out_kind),  32'(kinds15[i-1]));
      step();
    end
    check("l15_done_pulse", 32'(bus16.done),      32'd1);
    check("l15_end_valid",  32'(bus16.out_valid), 32'd0);
    check("l15_end_busy",   32'(bus16.busy),      32'd0);
    step();
    check("l15_done_once",  32'(bus16.done),      32'd0);
    step();

    // Limit 6 with out_ready toggling 1,0,0,1.
    bus16.limit = 16'd6; bus16.start = 1'b1; bus16.out_ready = 1'b1;
    step();
    bus16.start = 1'b0;
    idx = 0; dones = 0;
    prev_valid = 1'b0; prev_ready = 1'b1; prev_value = '0;
    for (int c = 0; c < 30; c++) begin
      r = ready_pat[c % 4];
      bus16.out_ready = r;
      if (prev_valid && !prev_ready && bus16.out_valid)
        check("l6_hold", 32'(bus16.out_value), 32'(prev_value));
      if (bus16.out_valid && r) begin
        if (idx < 6) begin
          check("l6_value", 32'(bus16.out_value), 32'(idx + 1));
          check("l6_kind",  32'(bus16.out_kind),  32'(kinds15[idx]));
        end
        idx++;
      end
      if (bus16.done) dones++;
      prev_valid = bus16.out_valid;
      prev_ready = r;
      prev_value = bus16.out_value;
      step();
    end
    check("l6_accepted", 32'(idx),   32'd6);
    check("l6_dones",    32'(dones), 32'd1);
    bus16.out_ready = 1'b1;

    // Limit 0: no output, done one cycle after start.
    bus16.limit = 16'd0; bus16.start = 1'b1;
    step();
    bus16.start = 1'b0;
    check("l0_valid", 32'(bus16.out_valid), 32'd0);
    check("l0_busy",  32'(bus16.busy),      32'd0);
    check("l0_done",  32'(bus16.done),      32'd1);
    step();
    check("l0_done_once", 32'(bus16.done),      32'd0);
    check("l0_valid2",    32'(bus16.out_valid), 32'd0);

    // Limit 1: single result then done.
    bus16.limit = 16'd1; bus16.start = 1'b1;
    step();
    bus16.start = 1'b0;
    check("l1_valid", 32'(bus16.out_valid), 32'd1);
    check("l1_value", 32'(bus16.out_value), 32'd1);
    check("l1_kind",  32'(bus16.out_kind),  32'd0);
    step();
    check("l1_done",  32'(bus16.done),      32'd1);
    check("l1_valid2", 32'(bus16.out_valid), 32'd0);
    step();

    // Limit 10 with start re-pulsed and limit changed to 3 mid-run.
    bus16.limit = 16'd10; bus16.start = 1'b1;
    step();
    n_acc = 0; dones = 0; last_val = '0;
    for (int c = 0; c < 30; c++) begin
      bus16.start = (c == 3);
      bus16.limit = (c >= 3) ? 16'd3 : 16'd10;
      if (bus16.out_valid) begin
        last_val = bus16.out_value;
        n_acc++;
      end
      if (bus16.done) dones++;
      step();
    end
    check("l10_last",  32'(last_val), 32'd10);
    check("l10_count", 32'(n_acc),    32'd10);
    check("l10_dones", 32'(dones),    32'd1);
    check("l10_idle_busy",  32'(bus16.busy),      32'd0);
    check("l10_idle_valid", 32'(bus16.out_valid), 32'd0);

    // Limit 20 interrupted by an asynchronous reset at value 7.
    bus16.limit = 16'd20; bus16.start = 1'b1;
    step();
    bus16.start = 1'b0;
    for (int c = 1; c < 7; c++) step();
    check("rst_run_value7", 32'(bus16.out_value), 32'd7);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus16.out_valid), 32'd0);
    check("arst_busy",  32'(bus16.busy),      32'd0);
    check("arst_done",  32'(bus16.done),      32'd0);
    check("arst_value", 32'(bus16.out_value), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("arst_hold_valid", 32'(bus16.out_valid), 32'd0);
    bus16.limit = 16'd2; bus16.start = 1'b1;
    step();
    bus16.start = 1'b0;
    check("post_rst_v1", 32'(bus16.out_value), 32'd1);
    check("post_rst_k1", 32'(bus16.out_kind),  32'd0);
    check("post_rst_ok1", 32'(bus16.out_valid), 32'd1);
    step();
    check("post_rst_v2", 32'(bus16.out_value), 32'd2);
    check("post_rst_ok2", 32'(bus16.out_valid), 32'd1);
    step();
    check("post_rst_done",  32'(bus16.done),      32'd1);
    check("post_rst_valid", 32'(bus16.out_valid), 32'd0);
    step();

    // WIDTH=4 with the maximum limit: reaches 15 without wrapping.
    bus4.limit = 4'd15; bus4.start = 1'b1; bus4.out_ready = 1'b1;
    step();
    bus4.start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 15; i++) begin
      check("w4_value", 32'(bus4.out_value), 32'(i));
      check("w4_kind",  32'(bus4.out_kind),  32'(kinds15[i-1]));
      step();
    end
    for (int c = 0; c < 4; c++) begin
      if (bus4.done) dones++;
      check("w4_no_valid", 32'(bus4.out_valid), 32'd0);
      step();
    end
    check("w4_dones",      32'(dones),          32'd1);
    check("w4_final_value", 32'(bus4.out_value), 32'd15);
    check("w4_final_kind",  32'(bus4.out_kind),  32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fizzbuzz_sequencer.md
Name: fizzbuzz_sequencer

Overview:
- Sequences the fizzbuzz datapath: counts 1..limit and classifies each value as number, fizz, buzz or fizzbuzz.
- Streams one result per accepted valid/ready handshake to a downstream consumer.
- Sits between a testbench or host start/limit interface and the per-value output stage.
- Uses wrapping mod-3 and mod-5 counters; no dividers.

Parameters:
- WIDTH, 16, width of limit and out_value; maximum legal limit is 2^WIDTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a run; accepted only in IDLE.
- limit  input  WIDTH  last value to emit; latched when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at end of run.
- out_valid  output  1  out_value/out_kind hold a valid result.
- out_ready  input  1  consumer accepts result when high with out_valid.
- out_value  output  WIDTH  current count value.
- out_kind  output  2  0=number, 1=fizz (div 3 only), 2=buzz (div 5 only), 3=fizzbuzz (div 15).

Behaviour:
- All outputs are registered. Reset values: state=IDLE, busy=0, done=0, out_valid=0, out_value=0, out_kind=0, mod3=0, mod5=0, limit_q=0.
- Reset is asynchronous. Asserting rst mid-run returns to IDLE immediately and drops out_valid with no further outputs. A run in flight is abandoned.
- States: IDLE, RUN, DONE.
- IDLE, start=1, limit>=1:
  - Latch limit_q=limit; out_value=1; mod3=1; mod5=1; out_kind=0.
  - out_valid=1 and busy=1 from the next cycle (latency 1); go to RUN.
- IDLE, start=1, limit=0: go to DONE; no output is produced; done=1 the next cycle.
- IDLE, start=0: remain in IDLE.
- RUN, handshake (out_valid & out_ready):
  - If out_value==limit_q: go to DONE; out_valid=0 and busy=0 next cycle.
  - Otherwise out_value+1. mod3 wraps 2->0 and mod5 wraps 4->0, each updated from its current value.
  - out_kind is computed from the next mod values: bit0 = (next mod3==0), bit1 = (next mod5==0).
  - The next result is presented the following cycle, so throughput is one result per cycle with out_ready held high.
- RUN, no handshake (out_ready=0): out_value and out_kind are held stable and out_valid stays 1 (AXI-style stability).
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. A start seen during DONE is ignored.
- start during RUN or DONE is ignored, and the limit input is ignored after latching; changes to limit mid-run have no effect.
- Counter width: out_value never wraps. The last value is limit_q ≤ 2^WIDTH-1, so no increment beyond limit occurs; limit=2^WIDTH-1 is legal.
- Reset-like state on return to IDLE: out_value and out_kind keep their last values, but out_valid=0. Consumers qualify on out_valid only.

Test Plan:
- Limit 15, out_ready=1 throughout, start pulsed at cycle 0:
  - Results at cycles 1..15 are values 1..15 with kinds 0,0,1,0,2,1,0,0,1,2,0,1,0,0,3.
  - done=1 at cycle 16 only; busy high during cycles 1..15.
- Limit 6, out_ready toggling 1,0,0,1,...:
  - Each value is held stable while out_ready=0.
  - Accepted sequence is exactly 1,2,3(fizz),4,5(buzz),6(fizz).
  - No duplicates and no drops; done pulses once.
- Limit 0 and limit 1:
  - limit 0 gives no out_valid and done=1 one cycle after start.
  - limit 1 gives a single result value 1, kind 0, then done.
- start re-pulsed and limit changed to 3 mid-run of limit 10: run still ends at 10; the extra start is ignored.
- rst asserted asynchronously mid-cycle at value 7 of a limit-20 run:
  - out_valid, busy and done go to 0 immediately.
  - A new start with limit 2 afterwards yields values 1,2 only.
- WIDTH=4, limit 15: final value 15, kind 3, no wrap to 0; done pulses once.
